hazard_ctrl_mc: RTL and testbench

Parametrised successor to the single-cycle pipeline hazard unit. Generates forwarding selects, load-use and branch-compare stalls, and E-stage flush for the 5-stage pipeline. Adds a sequential busy tracker for a fixed-latency multi-cycle multiply/divide unit (MDU) that owns HI/LO. Sits beside the datapath; all outputs feed the F/D/E pipeline register enables, the flush logic and the forwarding muxes.

---
 rtl/hazard_ctrl_mc.sv | 126 ++++++++++++
 tb/tb_hazard_ctrl_mc.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_mc.sv
`default_nettype none
// ============================================================================
// hazard_ctrl_mc : 5-stage pipeline hazard unit with forwarding, load-use /
//                  branch / MDU-busy stalls and a fixed-latency MDU tracker.
// Optional: define HAZARD_PERF_CNT_EN to add the stall_cycles counter.
// Revision: 1.0
// ============================================================================
module hazard_ctrl_mc #(
  parameter int ADDR_W = 5,
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rs_d,
  input  logic [ADDR_W-1:0] rt_d,
  input  logic              branch_d,
  input  logic              md_use_d,
  input  logic [ADDR_W-1:0] rs_e,
  input  logic [ADDR_W-1:0] rt_e,
  input  logic              reg_write_e,
  input  logic              mem_to_reg_e,
  input  logic [ADDR_W-1:0] write_reg_e,
  input  logic              reg_write_m,
  input  logic              mem_to_reg_m,
  input  logic [ADDR_W-1:0] write_reg_m,
  input  logic              reg_write_w,
  input  logic [ADDR_W-1:0] write_reg_w,
  input  logic              md_start_e,
  output logic              stall_f,
  output logic              stall_d,
  output logic              flush_e,
  output logic              forward_ad,
  output logic              forward_bd,
  output logic [1:0]        forward_ae,
  output logic [1:0]        forward_be,
  output logic              md_busy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cycles
`endif
);

  localparam logic [CNT_W-1:0] c_md_lat = CNT_W'(MD_LAT);

  logic [CNT_W-1:0] r_md_cnt;
  logic             w_rs_d_nz;
  logic             w_rt_d_nz;
  logic             w_rs_e_nz;
  logic             w_rt_e_nz;
  logic             w_lw_stall;
  logic             w_br_stall;
  logic             w_md_stall;
  logic             w_stall;

  assign w_rs_d_nz = (rs_d != '0);
  assign w_rt_d_nz = (rt_d != '0);
  assign w_rs_e_nz = (rs_e != '0);
  assign w_rt_e_nz = (rt_e != '0);

  // M-stage result has priority over W: it is the younger producer.
  always_comb begin
    forward_ae = 2'b00;
    if (w_rs_e_nz && reg_write_m && (rs_e == write_reg_m))
      forward_ae = 2'b10;
    else if (w_rs_e_nz && reg_write_w && (rs_e == write_reg_w))
      forward_ae = 2'b01;
  end

  always_comb begin
    forward_be = 2'b00;
    if (w_rt_e_nz && reg_write_m && (rt_e == write_reg_m))
      forward_be = 2'b10;
    else if (w_rt_e_nz && reg_write_w && (rt_e == write_reg_w))
      forward_be = 2'b01;
  end

  assign forward_ad = w_rs_d_nz && (rs_d == write_reg_m) && reg_write_m && !mem_to_reg_m;
  assign forward_bd = w_rt_d_nz && (rt_d == write_reg_m) && reg_write_m && !mem_to_reg_m;

  assign w_lw_stall = mem_to_reg_e && reg_write_e &&
                      ((w_rs_d_nz && (rs_d == write_reg_e)) ||
                       (w_rt_d_nz && (rt_d == write_reg_e)));

  // A branch resolving in D cannot use an E result or an M load value.
  assign w_br_stall = branch_d &&
                      ((reg_write_e &&
                        ((w_rs_d_nz && (rs_d == write_reg_e)) ||
                         (w_rt_d_nz && (rt_d == write_reg_e)))) ||
                       (mem_to_reg_m &&
                        ((w_rs_d_nz && (rs_d == write_reg_m)) ||
                         (w_rt_d_nz && (rt_d == write_reg_m)))));

  assign md_busy    = (r_md_cnt != '0);
  assign w_md_stall = md_use_d && md_busy;
  assign w_stall    = w_lw_stall || w_br_stall || w_md_stall;

  assign stall_f = w_stall;
  assign stall_d = w_stall;
  assign flush_e = w_stall;

  // A new issue reloads the full latency rather than extending the old one.
  always_ff @(posedge clk) begin
    if (!rst_n)
      r_md_cnt <= '0;
    else if (md_start_e)
      r_md_cnt <= c_md_lat;
    else if (r_md_cnt != '0)
      r_md_cnt <= r_md_cnt - CNT_W'(1);
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_stall_cycles;

  always_ff @(posedge clk) begin
    if (!rst_n)
      r_stall_cycles <= '0;
    else if (w_stall && (r_stall_cycles != 32'hFFFF_FFFF))
      r_stall_cycles <= r_stall_cycles + 32'd1;
  end

  assign stall_cycles = r_stall_cycles;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl_mc.sv
`default_nettype none
// tb_hazard_ctrl_mc : table-driven combinational vectors plus directed MDU,
// reset and optional stall-counter sequences.
module tb_hazard_ctrl_mc;

  logic       clk;
  logic       rst_n;
  logic [4:0] rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w;
  logic       branch_d, md_use_d, reg_write_e, mem_to_reg_e;
  logic       reg_write_m, mem_to_reg_m, reg_write_w, md_start_e;
  logic       stall_f, stall_d, flush_e, forward_ad, forward_bd, md_busy;
  logic [1:0] forward_ae, forward_be;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles;
`endif

  int checks   = 0;
  int failures = 0;

  hazard_ctrl_mc #(.ADDR_W(5), .MD_LAT(4), .CNT_W(3)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rs_d         (rs_d),
    .rt_d         (rt_d),
    .branch_d     (branch_d),
    .md_use_d     (md_use_d),
    .rs_e         (rs_e),
    .rt_e         (rt_e),
    .reg_write_e  (reg_write_e),
    .mem_to_reg_e (mem_to_reg_e),
    .write_reg_e  (write_reg_e),
    .reg_write_m  (reg_write_m),
    .mem_to_reg_m (mem_to_reg_m),
    .write_reg_m  (write_reg_m),
    .reg_write_w  (reg_write_w),
    .write_reg_w  (write_reg_w),
    .md_start_e   (md_start_e),
    .stall_f      (stall_f),
    .stall_d      (stall_d),
    .flush_e      (flush_e),
    .forward_ad   (forward_ad),
    .forward_bd   (forward_bd),
    .forward_ae   (forward_ae),
    .forward_be   (forward_be),
    .md_busy      (md_busy)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [4:0] rs_d, rt_d;
    logic       br, mdu;
    logic [4:0] rs_e, rt_e;
    logic       rwe, mre;
    logic [4:0] wre;
    logic       rwm, mrm;
    logic [4:0] wrm;
    logic       rww;
    logic [4:0] wrw;
    logic       e_stall, e_fad, e_fbd;
    logic [1:0] e_fae, e_fbe;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(string n,
      logic [4:0] a_rs_d, logic [4:0] a_rt_d, logic a_br, logic a_mdu,
      logic [4:0] a_rs_e, logic [4:0] a_rt_e,
      logic a_rwe, logic a_mre, logic [4:0] a_wre,
      logic a_rwm, logic a_mrm, logic [4:0] a_wrm,
      logic a_rww, logic [4:0] a_wrw,
      logic s, logic fad, logic fbd, logic [1:0] fae, logic [1:0] fbe);
    vec_t v;
    v.name = n;  v.rs_d = a_rs_d; v.rt_d = a_rt_d; v.br = a_br; v.mdu = a_mdu;
    v.rs_e = a_rs_e; v.rt_e = a_rt_e;
    v.rwe = a_rwe; v.mre = a_mre; v.wre = a_wre;
    v.rwm = a_rwm; v.mrm = a_mrm; v.wrm = a_wrm;
    v.rww = a_rww; v.wrw = a_wrw;
    v.e_stall = s; v.e_fad = fad; v.e_fbd = fbd; v.e_fae = fae; v.e_fbe = fbe;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_idle();
    rs_d = 0; rt_d = 0; branch_d = 0; md_use_d = 0; rs_e = 0; rt_e = 0;
    reg_write_e = 0; mem_to_reg_e = 0; write_reg_e = 0;
    reg_write_m = 0; mem_to_reg_m = 0; write_reg_m = 0;
    reg_write_w = 0; write_reg_w = 0; md_start_e = 0;
  endtask

  task automatic apply(vec_t v);
    rs_d = v.rs_d; rt_d = v.rt_d; branch_d = v.br; md_use_d = v.mdu;
    rs_e = v.rs_e; rt_e = v.rt_e;
    reg_write_e = v.rwe; mem_to_reg_e = v.mre; write_reg_e = v.wre;
    reg_write_m = v.rwm; mem_to_reg_m = v.mrm; write_reg_m = v.wrm;
    reg_write_w = v.rww; write_reg_w = v.wrw;
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_stall(string nm, logic exp);
    chk({nm, ".stall_f"}, 32'(stall_f), 32'(exp));
    chk({nm, ".stall_d"}, 32'(stall_d), 32'(exp));
    chk({nm, ".flush_e"}, 32'(flush_e), 32'(exp));
  endtask

  initial begin
    //                 rs_d rt_d br mdu rs_e rt_e rwe mre wre rwm mrm wrm rww wrw  st ad bd ae     be
    vecs[0]  = mk("idle",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    vecs[1]  = mk("lw_rs",     8, 0, 0, 0, 0, 0, 1, 1, 8, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00);
    vecs[2]  = mk("lw_zero",   0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    vecs[3]  = mk("lw_rt",     0, 8, 0, 0, 0, 0, 1, 1, 8, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00);
    vecs[4]  = mk("lw_nowr",   8, 0, 0, 0, 0, 0, 0, 1, 8, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    vecs[5]  = mk("fwd_m",     0, 0, 0, 0, 5, 0, 0, 0, 0, 1, 0, 5, 1, 5, 0, 0, 0, 2'b10, 2'b00);
    vecs[6]  = mk("fwd_w",     0, 0, 0, 0, 5, 0, 0, 0, 0, 0, 0, 5, 1, 5, 0, 0, 0, 2'b01, 2'b00);
    vecs[7]  = mk("fwd_zero",  0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00);
    vecs[8]  = mk("fwd_be_w",  0, 0, 0, 0, 0, 7, 0, 0, 0, 1, 0, 5, 1, 7, 0, 0, 0, 2'b00, 2'b01);
    vecs[9]  = mk("br_e",      0, 3, 1, 0, 0, 0, 1, 0, 3, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00);
    vecs[10] = mk("br_m_alu",  0, 3, 1, 0, 0, 0, 0, 0, 0, 1, 0, 3, 0, 0, 0, 0, 1, 2'b00, 2'b00);
    vecs[11] = mk("br_m_load", 0, 3, 1, 0, 0, 0, 0, 0, 0, 1, 1, 3, 0, 0, 1, 0, 0, 2'b00, 2'b00);
    vecs[12] = mk("fwd_ad",    4, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 4, 0, 0, 0, 1, 0, 2'b00, 2'b00);
    vecs[13] = mk("br_zero",   0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    vecs[14] = mk("md_idle",   0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    vecs[15] = mk("e_alu_nobr",3, 0, 0, 0, 0, 0, 1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);

    set_idle();
    rst_n = 1'b0;
    step();
    step();
    chk("reset.md_busy", 32'(md_busy), 32'd0);
    chk_stall("reset", 1'b0);
    chk("reset.forward_ae", 32'(forward_ae), 32'd0);
`ifdef HAZARD_PERF_CNT_EN
    chk("reset.stall_cycles", stall_cycles, 32'd0);
`endif
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 16; i++) begin
      apply(vecs[i]);
      #1;
      chk_stall(vecs[i].name, vecs[i].e_stall);
      chk({vecs[i].name, ".forward_ad"}, 32'(forward_ad), 32'(vecs[i].e_fad));
      chk({vecs[i].name, ".forward_bd"}, 32'(forward_bd), 32'(vecs[i].e_fbd));
      chk({vecs[i].name, ".forward_ae"}, 32'(forward_ae), 32'(vecs[i].e_fae));
      chk({vecs[i].name, ".forward_be"}, 32'(forward_be), 32'(vecs[i].e_fbe));
      step();
    end

    // MDU latency: busy for exactly four cycles after the issuing edge.
    set_idle();
    step();
    md_use_d = 1'b1;
    md_start_e = 1'b1;
    step();
    md_start_e = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("mdu_lat[%0d].md_busy", i), 32'(md_busy), 32'(i < 4));
      chk_stall($sformatf("mdu_lat[%0d]", i), (i < 4));
      step();
    end

    // Reset in the middle of an operation abandons it, even with a start asserted.
    md_start_e = 1'b1;
    step();
    md_start_e = 1'b0;
    chk("mdu_rst.pre_busy", 32'(md_busy), 32'd1);
    rst_n = 1'b0;
    md_start_e = 1'b1;
    step();
    chk("mdu_rst.md_busy", 32'(md_busy), 32'd0);
    chk_stall("mdu_rst", 1'b0);
    rst_n = 1'b1;
    md_start_e = 1'b0;
    step();
    chk("mdu_rst.after", 32'(md_busy), 32'd0);

    // Re-issue while busy (coincident with the D-stage stall) reloads to full latency.
    md_start_e = 1'b1;
    step();
    md_start_e = 1'b0;
    step();
    step();
    chk_stall("mdu_reload.pre", 1'b1);
    md_start_e = 1'b1;
    step();
    md_start_e = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("mdu_reload[%0d].md_busy", i), 32'(md_busy), 32'(i < 4));
      chk_stall($sformatf("mdu_reload[%0d]", i), (i < 4));
      step();
    end

`ifdef HAZARD_PERF_CNT_EN
    set_idle();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("perf.cleared", stall_cycles, 32'd0);
    apply(vecs[1]);
    for (int i = 0; i < 3; i++) step();
    set_idle();
    chk("perf.after_lw", stall_cycles, 32'd3);
    md_start_e = 1'b1;
    step();
    md_start_e = 1'b0;
    md_use_d = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("perf.total", stall_cycles, 32'd7);
    chk_stall("perf.released", 1'b0);
    step();
    chk("perf.hold", stall_cycles, 32'd7);
    rst_n = 1'b0;
    step();
    chk("perf.reset", stall_cycles, 32'd0);
    rst_n = 1'b1;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
